amba_axi4_lite_write_arbiter: RTL and testbench

Two-manager to one-subordinate write-path arbiter for the AXI4-Lite interfaces checked by the protocol checker. It grants the shared subordinate AW/W/B path to one manager at a time, keeps at most one write transaction outstanding, and routes the response back to the granted manager. It sits between two AXI4-Lite write masters and a single AXI4-Lite slave. The protocol checker can be bound on every port with no changes.

---
 rtl/amba_axi4_lite_write_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_amba_axi4_lite_write_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/amba_axi4_lite_write_arbiter.sv
// Two-manager to one-subordinate AXI4-Lite write-path arbiter with a single outstanding write.
// Optional round-robin arbitration is enabled by defining AXI4_ARB_ROUND_ROBIN_EN; otherwise M0 has fixed priority.
module amba_axi4_lite_write_arbiter #(
   parameter int ADDRESS_WIDTH = 32,
   parameter int DATA_WIDTH    = 64
) (
   input  logic                       ACLK,
   input  logic                       ARESETn,
   // Manager 0
   input  logic                       M0_AWVALID,
   output logic                       M0_AWREADY,
   input  logic [ADDRESS_WIDTH-1:0]   M0_AWADDR,
   input  logic [2:0]                 M0_AWPROT,
   input  logic                       M0_WVALID,
   output logic                       M0_WREADY,
   input  logic [DATA_WIDTH-1:0]      M0_WDATA,
   input  logic [DATA_WIDTH/8-1:0]    M0_WSTRB,
   output logic                       M0_BVALID,
   input  logic                       M0_BREADY,
   output logic [1:0]                 M0_BRESP,
   // Manager 1
   input  logic                       M1_AWVALID,
   output logic                       M1_AWREADY,
   input  logic [ADDRESS_WIDTH-1:0]   M1_AWADDR,
   input  logic [2:0]                 M1_AWPROT,
   input  logic                       M1_WVALID,
   output logic                       M1_WREADY,
   input  logic [DATA_WIDTH-1:0]      M1_WDATA,
   input  logic [DATA_WIDTH/8-1:0]    M1_WSTRB,
   output logic                       M1_BVALID,
   input  logic                       M1_BREADY,
   output logic [1:0]                 M1_BRESP,
   // Subordinate
   output logic                       S_AWVALID,
   output logic [ADDRESS_WIDTH-1:0]   S_AWADDR,
   output logic [2:0]                 S_AWPROT,
   input  logic                       S_AWREADY,
   output logic                       S_WVALID,
   output logic [DATA_WIDTH-1:0]      S_WDATA,
   output logic [DATA_WIDTH/8-1:0]    S_WSTRB,
   input  logic                       S_WREADY,
   input  logic                       S_BVALID,
   input  logic [1:0]                 S_BRESP,
   output logic                       S_BREADY,
   output logic [1:0]                 GRANT
);

   localparam int STRB_WIDTH = DATA_WIDTH/8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_XFER = 2'b01,
      ST_RESP = 2'b10
   } state_t;

   state_t                   r_state;
   logic [1:0]               r_grant;
   logic                     r_aw_done;
   logic                     r_w_done;
   logic                     r_last_grant;   // 1'b1 = M1 was the last winner

   logic                     w_xfer;
   logic                     w_resp;
   logic [1:0]               w_req;
   logic                     w_prefer_m1;
   logic                     w_aw_hs;
   logic                     w_w_hs;
   logic                     w_b_hs;
   logic                     w_sel_awvalid;
   logic [ADDRESS_WIDTH-1:0] w_sel_awaddr;
   logic [2:0]               w_sel_awprot;
   logic                     w_sel_wvalid;
   logic [DATA_WIDTH-1:0]    w_sel_wdata;
   logic [STRB_WIDTH-1:0]    w_sel_wstrb;
   logic                     w_sel_bready;

   // One-hot winner from the AW requests; a contest goes to M1 only when preferred.
   function automatic logic [1:0] f_pick(input logic [1:0] req, input logic prefer_m1);
      logic [1:0] win;
      case (req)
         2'b01:   win = 2'b01;
         2'b10:   win = 2'b10;
         2'b11:   win = prefer_m1 ? 2'b10 : 2'b01;
         default: win = 2'b00;
      endcase
      return win;
   endfunction

`ifdef AXI4_ARB_ROUND_ROBIN_EN
   assign w_prefer_m1 = ~r_last_grant;
`else
   // last_grant is still tracked, but fixed priority never prefers M1
   assign w_prefer_m1 = r_last_grant & 1'b0;
`endif

   assign w_xfer = (r_state == ST_XFER);
   assign w_resp = (r_state == ST_RESP);
   assign w_req  = {M1_AWVALID, M0_AWVALID};

   // Select the granted manager's request-side signals.
   always_comb begin
      w_sel_awvalid = 1'b0;
      w_sel_awaddr  = {ADDRESS_WIDTH{1'b0}};
      w_sel_awprot  = 3'b000;
      w_sel_wvalid  = 1'b0;
      w_sel_wdata   = {DATA_WIDTH{1'b0}};
      w_sel_wstrb   = {STRB_WIDTH{1'b0}};
      w_sel_bready  = 1'b0;
      if (r_grant[1]) begin
         w_sel_awvalid = M1_AWVALID;
         w_sel_awaddr  = M1_AWADDR;
         w_sel_awprot  = M1_AWPROT;
         w_sel_wvalid  = M1_WVALID;
         w_sel_wdata   = M1_WDATA;
         w_sel_wstrb   = M1_WSTRB;
         w_sel_bready  = M1_BREADY;
      end else if (r_grant[0]) begin
         w_sel_awvalid = M0_AWVALID;
         w_sel_awaddr  = M0_AWADDR;
         w_sel_awprot  = M0_AWPROT;
         w_sel_wvalid  = M0_WVALID;
         w_sel_wdata   = M0_WDATA;
         w_sel_wstrb   = M0_WSTRB;
         w_sel_bready  = M0_BREADY;
      end else begin
         w_sel_awvalid = 1'b0;
         w_sel_bready  = 1'b0;
      end
   end

   // Payload is zero outside XFER so an idle bus never shows stale data
   assign S_AWVALID = w_xfer & ~r_aw_done & w_sel_awvalid;
   assign S_AWADDR  = w_xfer ? w_sel_awaddr : {ADDRESS_WIDTH{1'b0}};
   assign S_AWPROT  = w_xfer ? w_sel_awprot : 3'b000;
   assign S_WVALID  = w_xfer & ~r_w_done & w_sel_wvalid;
   assign S_WDATA   = w_xfer ? w_sel_wdata : {DATA_WIDTH{1'b0}};
   assign S_WSTRB   = w_xfer ? w_sel_wstrb : {STRB_WIDTH{1'b0}};
   assign S_BREADY  = w_resp & w_sel_bready;

   assign M0_AWREADY = w_xfer & r_grant[0] & ~r_aw_done & S_AWREADY;
   assign M1_AWREADY = w_xfer & r_grant[1] & ~r_aw_done & S_AWREADY;
   assign M0_WREADY  = w_xfer & r_grant[0] & ~r_w_done & S_WREADY;
   assign M1_WREADY  = w_xfer & r_grant[1] & ~r_w_done & S_WREADY;
   assign M0_BVALID  = w_resp & r_grant[0] & S_BVALID;
   assign M1_BVALID  = w_resp & r_grant[1] & S_BVALID;
   assign M0_BRESP   = (w_resp & r_grant[0]) ? S_BRESP : 2'b00;
   assign M1_BRESP   = (w_resp & r_grant[1]) ? S_BRESP : 2'b00;

   assign w_aw_hs = S_AWVALID & S_AWREADY;
   assign w_w_hs  = S_WVALID & S_WREADY;
   assign w_b_hs  = S_BVALID & S_BREADY;
   assign GRANT   = r_grant;

   // Arbitration FSM with grant, handshake-done flags and last winner.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         r_state      <= ST_IDLE;
         r_grant      <= 2'b00;
         r_aw_done    <= 1'b0;
         r_w_done     <= 1'b0;
         r_last_grant <= 1'b1;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (|w_req) begin
                  r_grant   <= f_pick(w_req, w_prefer_m1);
                  r_aw_done <= 1'b0;
                  r_w_done  <= 1'b0;
                  r_state   <= ST_XFER;
               end else begin
                  r_grant   <= 2'b00;
               end
            end
            ST_XFER: begin
               r_aw_done <= r_aw_done | w_aw_hs;
               r_w_done  <= r_w_done | w_w_hs;
               if ((r_aw_done | w_aw_hs) && (r_w_done | w_w_hs)) begin
                  r_state <= ST_RESP;
               end else begin
                  r_state <= ST_XFER;
               end
            end
            ST_RESP: begin
               if (w_b_hs) begin
                  r_state      <= ST_IDLE;
                  r_grant      <= 2'b00;
                  r_last_grant <= r_grant[1];
               end else begin
                  r_state      <= ST_RESP;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_grant <= 2'b00;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_amba_axi4_lite_write_arbiter.sv
// Self-checking bench: directed vector table, hand sequences for multi-cycle corners, and
// randomized traffic compared against a transaction-level owner model.
module tb_amba_axi4_lite_write_arbiter;

   localparam int AW = 32;
   localparam int DW = 64;
   localparam int SW = DW/8;
`ifdef AXI4_ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic ACLK = 1'b0;
   logic ARESETn;
   always #5 ACLK = ~ACLK;

   logic [1:0]    aw_v, w_v, b_r;
   logic [AW-1:0] aw_addr [2];
   logic [2:0]    aw_prot [2];
   logic [DW-1:0] w_data  [2];
   logic [SW-1:0] w_strb  [2];
   logic [1:0]    aw_rdy, w_rdy, b_vld;
   logic [1:0]    m0_bresp, m1_bresp;
   logic          s_awv, s_awr, s_wv, s_wr, s_bv, s_br;
   logic [AW-1:0] s_awaddr;
   logic [2:0]    s_awprot;
   logic [DW-1:0] s_wdata;
   logic [SW-1:0] s_wstrb;
   logic [1:0]    s_bresp, grant;

   int checks = 0;
   int failures = 0;

   amba_axi4_lite_write_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .M0_AWVALID(aw_v[0]), .M0_AWREADY(aw_rdy[0]), .M0_AWADDR(aw_addr[0]), .M0_AWPROT(aw_prot[0]),
      .M0_WVALID(w_v[0]), .M0_WREADY(w_rdy[0]), .M0_WDATA(w_data[0]), .M0_WSTRB(w_strb[0]),
      .M0_BVALID(b_vld[0]), .M0_BREADY(b_r[0]), .M0_BRESP(m0_bresp),
      .M1_AWVALID(aw_v[1]), .M1_AWREADY(aw_rdy[1]), .M1_AWADDR(aw_addr[1]), .M1_AWPROT(aw_prot[1]),
      .M1_WVALID(w_v[1]), .M1_WREADY(w_rdy[1]), .M1_WDATA(w_data[1]), .M1_WSTRB(w_strb[1]),
      .M1_BVALID(b_vld[1]), .M1_BREADY(b_r[1]), .M1_BRESP(m1_bresp),
      .S_AWVALID(s_awv), .S_AWADDR(s_awaddr), .S_AWPROT(s_awprot), .S_AWREADY(s_awr),
      .S_WVALID(s_wv), .S_WDATA(s_wdata), .S_WSTRB(s_wstrb), .S_WREADY(s_wr),
      .S_BVALID(s_bv), .S_BRESP(s_bresp), .S_BREADY(s_br),
      .GRANT(grant)
   );

   typedef struct packed {
      logic [1:0]  aw, w, b;
      logic        sawr, swr, sbv;
      logic [1:0]  sbresp;
      logic [1:0]  e_grant;
      logic [8:0]  e_vr;     // {S_AWVALID,S_WVALID,S_BREADY,AWREADY[1:0],WREADY[1:0],BVALID[1:0]}
      logic [3:0]  e_bresp;  // {M1_BRESP,M0_BRESP}
      logic [31:0] e_addr;
   } vec_t;

   vec_t tbl [9];

   function automatic vec_t mk(input logic [1:0] aw, input logic [1:0] w, input logic [1:0] b,
                               input logic sawr, input logic swr, input logic sbv, input logic [1:0] sbresp,
                               input logic [1:0] eg, input logic [8:0] evr, input logic [3:0] ebr,
                               input logic [31:0] ea);
      vec_t v;
      v.aw = aw; v.w = w; v.b = b; v.sawr = sawr; v.swr = swr; v.sbv = sbv; v.sbresp = sbresp;
      v.e_grant = eg; v.e_vr = evr; v.e_bresp = ebr; v.e_addr = ea;
      return v;
   endfunction

   function automatic logic [8:0] vr_now();
      return {s_awv, s_wv, s_br, aw_rdy, w_rdy, b_vld};
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic clr_inputs();
      aw_v = 2'b00; w_v = 2'b00; b_r = 2'b00;
      s_awr = 1'b0; s_wr = 1'b0; s_bv = 1'b0; s_bresp = 2'b00;
   endtask

   task automatic apply_reset();
      ARESETn = 1'b0;
      clr_inputs();
      aw_v = 2'b11; w_v = 2'b11; s_awr = 1'b1; s_wr = 1'b1; s_bv = 1'b1;
      repeat (2) @(posedge ACLK);
      #1;
      chk("reset_grant", grant, 2'b00);
      chk("reset_vr", vr_now(), 9'd0);
      clr_inputs();
      @(negedge ACLK);
      ARESETn = 1'b1;
   endtask

   task automatic step();
      @(posedge ACLK);
      #1;
   endtask

   // Model state: owner (-1 idle), outstanding AW/W of the owner, last winner
   int        own, last;
   bit        need_aw, need_w;
   logic [1:0] hs_aw, hs_w;

   initial begin
      logic [1:0] exp_win [3];
      logic [1:0] e_grant, e_awr, e_wr, e_bv;
      logic       e_awv, e_wv, e_br;
      logic [3:0] e_bresp;
      logic [106:0] e_pay;

      aw_addr[0] = 32'h0000_0100; aw_addr[1] = 32'h0000_0200;
      aw_prot[0] = 3'b000;        aw_prot[1] = 3'b010;
      w_data[0]  = 64'hA5;        w_data[1]  = 64'h5A;
      w_strb[0]  = 8'hFF;         w_strb[1]  = 8'h0F;

      tbl[0] = mk(2'b01, 2'b01, 2'b01, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 9'b000000000, 4'b0000, 32'h0);
      tbl[1] = mk(2'b01, 2'b01, 2'b01, 1'b1, 1'b1, 1'b0, 2'b00, 2'b01, 9'b110010100, 4'b0000, 32'h100);
      tbl[2] = mk(2'b00, 2'b00, 2'b01, 1'b1, 1'b1, 1'b1, 2'b00, 2'b01, 9'b001000001, 4'b0000, 32'h0);
      tbl[3] = mk(2'b10, 2'b00, 2'b10, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 9'b000000000, 4'b0000, 32'h0);
      tbl[4] = mk(2'b10, 2'b10, 2'b10, 1'b1, 1'b0, 1'b0, 2'b00, 2'b10, 9'b110100000, 4'b0000, 32'h200);
      tbl[5] = mk(2'b00, 2'b10, 2'b10, 1'b1, 1'b1, 1'b1, 2'b10, 2'b10, 9'b010001000, 4'b0000, 32'h200);
      tbl[6] = mk(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 2'b10, 2'b10, 9'b000000010, 4'b1000, 32'h0);
      tbl[7] = mk(2'b00, 2'b00, 2'b10, 1'b0, 1'b0, 1'b1, 2'b10, 2'b10, 9'b001000010, 4'b1000, 32'h0);
      tbl[8] = mk(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 9'b000000000, 4'b0000, 32'h0);

      apply_reset();
      for (int r = 0; r < 9; r++) begin
         step();
         aw_v = tbl[r].aw; w_v = tbl[r].w; b_r = tbl[r].b;
         s_awr = tbl[r].sawr; s_wr = tbl[r].swr; s_bv = tbl[r].sbv; s_bresp = tbl[r].sbresp;
         #1;
         chk($sformatf("row%0d_grant", r), grant, tbl[r].e_grant);
         chk($sformatf("row%0d_vr", r), vr_now(), tbl[r].e_vr);
         chk($sformatf("row%0d_bresp", r), {m1_bresp, m0_bresp}, tbl[r].e_bresp);
         chk($sformatf("row%0d_addr", r), s_awaddr, tbl[r].e_addr);
      end

      // Both managers keep requesting: winners of three back-to-back contests
      exp_win[0] = 2'b01;
      exp_win[1] = RR ? 2'b10 : 2'b01;
      exp_win[2] = 2'b01;
      apply_reset();
      for (int c = 0; c < 8; c++) begin
         step();
         aw_v = 2'b11; w_v = 2'b11; b_r = 2'b11; s_awr = 1'b1; s_wr = 1'b1; s_bv = 1'b1;
         #1;
         if (c % 3 == 1) chk($sformatf("contest%0d_grant", c / 3), grant, exp_win[c / 3]);
      end

      // W before AW on M1, M0 offers W only and must never see READY
      apply_reset();
      step(); w_v = 2'b11; b_r = 2'b10; s_wr = 1'b1; s_bv = 1'b1; #1;
      chk("wfirst_c0_grant", grant, 2'b00); chk("wfirst_c0_vr", vr_now(), 9'd0);
      step(); #1;
      chk("wfirst_c1_grant", grant, 2'b00); chk("wfirst_c1_vr", vr_now(), 9'd0);
      step(); aw_v = 2'b10; #1;
      chk("wfirst_c2_grant", grant, 2'b00);
      step(); #1;
      chk("wfirst_c3_grant", grant, 2'b10); chk("wfirst_c3_vr", vr_now(), 9'b110001000);
      step(); w_v = 2'b01; #1;
      chk("wfirst_c4_vr", vr_now(), 9'b100000000);
      step(); s_awr = 1'b1; #1;
      chk("wfirst_c5_vr", vr_now(), 9'b100100000);
      step(); aw_v = 2'b00; #1;
      chk("wfirst_c6_grant", grant, 2'b10); chk("wfirst_c6_vr", vr_now(), 9'b001000010);
      step(); #1;
      chk("wfirst_c7_grant", grant, 2'b00);

      // Reset asserted while in RESP, then a contest after release
      apply_reset();
      step(); aw_v = 2'b01; w_v = 2'b01; s_awr = 1'b1; s_wr = 1'b1; s_bv = 1'b1; s_bresp = 2'b01; #1;
      step(); #1;
      step(); aw_v = 2'b00; w_v = 2'b00; #1;
      chk("rstresp_grant", grant, 2'b01);
      chk("rstresp_vr", vr_now(), 9'b000000001);
      chk("rstresp_bresp", {m1_bresp, m0_bresp}, 4'b0001);
      #2;
      ARESETn = 1'b0;
      #1;
      chk("rstmid_grant", grant, 2'b00);
      chk("rstmid_vr", vr_now(), 9'd0);
      chk("rstmid_bresp", {m1_bresp, m0_bresp}, 4'b0000);
      repeat (2) @(posedge ACLK);
      @(negedge ACLK);
      ARESETn = 1'b1;
      aw_v = 2'b11; w_v = 2'b11; b_r = 2'b11;
      step();
      chk("rstafter_grant", grant, 2'b01);

      // Randomized traffic against the owner model
      apply_reset();
      own = -1; last = 1; need_aw = 1'b0; need_w = 1'b0; hs_aw = 2'b00; hs_w = 2'b00;
      for (int n = 0; n < 1500; n++) begin
         step();
         for (int i = 0; i < 2; i++) begin
            if (!aw_v[i] || hs_aw[i]) begin
               aw_v[i] = ($urandom_range(3) == 0);
               aw_addr[i] = $urandom;
               aw_prot[i] = 3'($urandom_range(7));
            end
            if (!w_v[i] || hs_w[i]) begin
               w_v[i] = ($urandom_range(2) == 0);
               w_data[i] = {$urandom, $urandom};
               w_strb[i] = 8'($urandom_range(255));
            end
            b_r[i] = 1'($urandom_range(1));
         end
         s_awr = 1'($urandom_range(1)); s_wr = 1'($urandom_range(1));
         s_bv = 1'($urandom_range(1)); s_bresp = 2'($urandom_range(3));
         #1;
         e_grant = 2'b00; e_awr = 2'b00; e_wr = 2'b00; e_bv = 2'b00;
         e_awv = 1'b0; e_wv = 1'b0; e_br = 1'b0; e_bresp = 4'b0000; e_pay = '0;
         if (own >= 0) begin
            e_grant = (own == 0) ? 2'b01 : 2'b10;
            if (need_aw || need_w) begin
               e_awv = need_aw && aw_v[own];
               e_wv  = need_w && w_v[own];
               e_pay = {aw_addr[own], aw_prot[own], w_data[own], w_strb[own]};
               e_awr[own] = need_aw && s_awr;
               e_wr[own]  = need_w && s_wr;
            end else begin
               e_br = b_r[own];
               e_bv[own] = s_bv;
               e_bresp = (own == 0) ? {2'b00, s_bresp} : {s_bresp, 2'b00};
            end
         end
         chk("rnd_grant", grant, e_grant);
         chk("rnd_vr", vr_now(), {e_awv, e_wv, e_br, e_awr, e_wr, e_bv});
         chk("rnd_bresp", {m1_bresp, m0_bresp}, e_bresp);
         chk("rnd_payload", {s_awaddr, s_awprot, s_wdata, s_wstrb}, e_pay);
         hs_aw = aw_v & e_awr;
         hs_w  = w_v & e_wr;
         if (own < 0) begin
            if (aw_v != 2'b00) begin
               if (aw_v == 2'b11) own = RR ? (1 - last) : 0;
               else own = aw_v[0] ? 0 : 1;
               need_aw = 1'b1; need_w = 1'b1;
            end
         end else if (need_aw || need_w) begin
            if (hs_aw[own]) need_aw = 1'b0;
            if (hs_w[own]) need_w = 1'b0;
         end else if (s_bv && b_r[own]) begin
            last = own;
            own = -1;
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
